// File: rtl/pattern_sequencer.sv
// Raster timing and pattern-mode scheduler for the test pattern datapath.
// Counters feed the generator; sync/de/frame_start are registered one cycle later to match its RGB.
module pattern_sequencer #(
  parameter int unsigned HMAX            = 800,
  parameter int unsigned VMAX            = 525,
  parameter int unsigned HA              = 640,
  parameter int unsigned VA              = 480,
  parameter int unsigned HFP             = 16,
  parameter int unsigned HSW             = 96,
  parameter int unsigned VFP             = 10,
  parameter int unsigned VSW             = 2,
  parameter bit          SYNC_POL        = 1'b0,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned FRAMES_PER_MODE = 60,
  localparam int unsigned HW             = $clog2(HMAX),
  localparam int unsigned VW             = $clog2(VMAX),
  localparam int unsigned MW             = $clog2(NUM_MODES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_auto,
  input  logic          i_mode_valid,
  input  logic [MW-1:0] i_mode,
  output logic          o_mode_ready,
  output logic [HW-1:0] o_hcount,
  output logic [VW-1:0] o_vcount,
  output logic [MW-1:0] o_mode,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic          o_frame_start,
  output logic          o_busy
);

  localparam int unsigned FW  = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam int unsigned HCW = HW + 1;
  localparam int unsigned VCW = VW + 1;

  localparam logic [HW-1:0]  HLast     = HW'(HMAX - 1);
  localparam logic [VW-1:0]  VLast     = VW'(VMAX - 1);
  localparam logic [MW-1:0]  ModeLast  = MW'(NUM_MODES - 1);
  localparam logic [FW-1:0]  FrameLast = FW'(FRAMES_PER_MODE - 1);
  // One extra bit so sync windows ending exactly at HMAX/VMAX still compare correctly.
  localparam logic [HCW-1:0] HActEnd   = HCW'(HA);
  localparam logic [HCW-1:0] HsStart   = HCW'(HA + HFP);
  localparam logic [HCW-1:0] HsEnd     = HCW'(HA + HFP + HSW);
  localparam logic [VCW-1:0] VActEnd   = VCW'(VA);
  localparam logic [VCW-1:0] VsStart   = VCW'(VA + VFP);
  localparam logic [VCW-1:0] VsEnd     = VCW'(VA + VFP + VSW);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q;
  logic            pending_q;
  logic [MW-1:0]   req_mode_q;
  logic [FW-1:0]   frame_cnt_q;

  logic            active;
  logic            h_wrap;
  logic            boundary;
  logic            accept;
  logic [MW-1:0]   mode_clamped;
  logic [MW-1:0]   mode_next_auto;
  logic [HCW-1:0]  hcx;
  logic [VCW-1:0]  vcx;
  logic            de_next;
  logic            hs_next;
  logic            vs_next;
  logic            fs_next;

  always_comb begin
    active         = (state_q != StIdle);
    h_wrap         = (o_hcount == HLast);
    boundary       = active && h_wrap && (o_vcount == VLast);
    accept         = i_mode_valid && o_mode_ready;
    mode_clamped   = (i_mode > ModeLast) ? ModeLast : i_mode;
    mode_next_auto = (o_mode == ModeLast) ? '0 : o_mode + MW'(1);
    hcx            = {1'b0, o_hcount};
    vcx            = {1'b0, o_vcount};
    de_next        = active && (hcx < HActEnd) && (vcx < VActEnd);
    hs_next        = active && (hcx >= HsStart) && (hcx < HsEnd);
    vs_next        = active && (vcx >= VsStart) && (vcx < VsEnd);
    fs_next        = active && (o_hcount == '0) && (o_vcount == '0);
  end

  assign o_mode_ready = ~pending_q;
  assign o_busy       = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_mode        <= '0;
      frame_cnt_q   <= '0;
      pending_q     <= 1'b0;
      req_mode_q    <= '0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_de          <= de_next;
      o_hsync       <= hs_next ? SYNC_POL : ~SYNC_POL;
      o_vsync       <= vs_next ? SYNC_POL : ~SYNC_POL;
      o_frame_start <= fs_next;

      if (!active) begin
        o_hcount <= '0;
        o_vcount <= '0;
        if (i_en) state_q <= StRun;
      end else begin
        if (h_wrap) begin
          o_hcount <= '0;
          o_vcount <= (o_vcount == VLast) ? '0 : o_vcount + VW'(1);
        end else begin
          o_hcount <= o_hcount + HW'(1);
        end
        // A disable seen on the boundary cycle itself ends the run right there.
        if (i_en)          state_q <= StRun;
        else if (boundary) state_q <= StIdle;
        else               state_q <= StDrain;
      end

      if (!active) begin
        if (accept) begin
          o_mode      <= mode_clamped;
          frame_cnt_q <= '0;
        end
      end else if (boundary) begin
        if (accept || pending_q) begin
          o_mode      <= accept ? mode_clamped : req_mode_q;
          frame_cnt_q <= '0;
          pending_q   <= 1'b0;
        end else if (i_auto) begin
          if (frame_cnt_q == FrameLast) begin
            frame_cnt_q <= '0;
            o_mode      <= mode_next_auto;
          end else begin
            frame_cnt_q <= frame_cnt_q + FW'(1);
          end
        end
      end else if (accept) begin
        pending_q  <= 1'b1;
        req_mode_q <= mode_clamped;
      end
    end
  end

endmodule
